// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit (divider and multiplier successors).
// Contents:
//   div_state_t        - sequencing states of the divider
//   SIGN_POS, SIGN_NEG - encodings of a recorded result sign
package multdiv_pkg;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_t;

    // Recorded sign of a result: negative results are negated in the fix-up step
    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/div_param_step.sv
// One restoring-division iteration. This block is purely combinational.
// Ports:
//   p_in / p_out   - partial remainder, WIDTH+1 bits, before and after the iteration
//   q_in / q_out   - dividend/quotient shift register, before and after the iteration
//   divisor        - divisor magnitude
// Two copies in series form a 2-bit-per-cycle datapath.
module div_param_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH-1:0] q_out
);

    // One bit of headroom above P so that the trial sign is an explicit borrow
    logic [WIDTH+1:0] p_sh;
    logic [WIDTH+1:0] trial;

    // Shift {P,Q} left, trial-subtract, and keep the result if it did not borrow
    always_comb begin
        p_sh  = {p_in, q_in[WIDTH-1]};
        trial = p_sh - {2'b00, divisor};
        if (trial[WIDTH+1]) begin
            p_out = p_sh[WIDTH:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end else begin
            p_out = trial[WIDTH:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_param.sv
// Parameterised sequential signed/unsigned restoring divider.
// Ports:
//   clock, reset                  - rising-edge clock, async active-high reset
//   data_operandA / data_operandB - dividend / divisor, sampled on a start edge
//   ctrl_DIV, ctrl_signed         - start pulse and signed-mode select
//   data_quotient, data_remainder - results; they hold until the next completion
//   data_exception                - divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY                - one-cycle pulse when the results are valid
//   busy                          - operation in progress
// A start takes priority in every state, so it aborts an operation that is in flight.
module div_param
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // Two's-complement negate, wrapping at WIDTH bits
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] dividend_raw;
    logic             quo_sign;
    logic             rem_sign;

    logic [WIDTH:0]   part_rem_nxt;
    logic [WIDTH-1:0] quo_sh_nxt;
    logic             a_neg;
    logic             b_neg;

    // Operand signs matter only in signed mode
    assign a_neg = ctrl_signed & data_operandA[WIDTH-1];
    assign b_neg = ctrl_signed & data_operandB[WIDTH-1];

    div_param_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in    (part_rem),
        .q_in    (quo_sh),
        .divisor (divisor_mag),
        .p_out   (part_rem_nxt),
        .q_out   (quo_sh_nxt)
    );

    // Sequencer, datapath registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            part_rem       <= '0;
            quo_sh         <= '0;
            divisor_mag    <= '0;
            dividend_raw   <= '0;
            quo_sign       <= SIGN_POS;
            rem_sign       <= SIGN_POS;
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            if (ctrl_DIV) begin
                // The most-negative value has a magnitude that still fits in WIDTH unsigned bits
                quo_sh       <= a_neg ? negate(data_operandA) : data_operandA;
                divisor_mag  <= b_neg ? negate(data_operandB) : data_operandB;
                dividend_raw <= data_operandA;
                part_rem     <= '0;
                quo_sign     <= a_neg ^ b_neg;
                rem_sign     <= a_neg;
                cnt          <= '0;
                busy         <= 1'b1;
                state        <= (data_operandB == '0) ? ZERO : RUN;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        part_rem <= part_rem_nxt;
                        quo_sh   <= quo_sh_nxt;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        data_quotient  <= (quo_sign == SIGN_NEG) ? negate(quo_sh) : quo_sh;
                        data_remainder <= (rem_sign == SIGN_NEG) ? negate(part_rem[WIDTH-1:0])
                                                                 : part_rem[WIDTH-1:0];
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                    ZERO: begin
                        data_quotient  <= '1;
                        data_remainder <= dividend_raw;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Self-checking bench for div_param. It drives a 32-bit and an 8-bit instance.
// A reference model computes results with plain integer division and a per-operation
// completion time. One compare process checks both DUTs against the model on every
// cycle, and directed operations pin the results to hand-computed constants.
module tb_div_param;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        e;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a1, b1, q1, r1;
    logic        st1, sg1, e1, rdy1, bz1;
    logic [7:0]  a2, b2, q2, r2;
    logic        st2, sg2, e2, rdy2, bz2;

    div_param #(.WIDTH(32)) u_div32 (
        .clock(clk), .reset(rst), .data_operandA(a1), .data_operandB(b1),
        .ctrl_DIV(st1), .ctrl_signed(sg1), .data_quotient(q1), .data_remainder(r1),
        .data_exception(e1), .data_resultRDY(rdy1), .busy(bz1)
    );

    div_param #(.WIDTH(8)) u_div8 (
        .clock(clk), .reset(rst), .data_operandA(a2), .data_operandB(b2),
        .ctrl_DIV(st2), .ctrl_signed(sg2), .data_quotient(q2), .data_remainder(r2),
        .data_exception(e2), .data_resultRDY(rdy2), .busy(bz2)
    );

    int tests = 0;
    int fails = 0;
    int nrdy1 = 0;
    int nrdy2 = 0;
    bit chk_on = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference division: truncation toward zero, remainder takes the dividend's sign
    function automatic res_t ref_div(input logic [63:0] a, input logic [63:0] b,
                                     input bit s, input int w);
        res_t        res;
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            res.q = mask;
            res.r = a & mask;
            res.e = 1'b1;
        end else if (s) begin
            sa    = longint'(a << (64 - w)) >>> (64 - w);
            sb    = longint'(b << (64 - w)) >>> (64 - w);
            res.q = 64'(sa / sb) & mask;
            res.r = 64'(sa % sb) & mask;
            res.e = 1'b0;
        end else begin
            res.q = a / b;
            res.r = a % b;
            res.e = 1'b0;
        end
        return res;
    endfunction

    // Model of the 32-bit instance
    longint      cyc1, due1;
    bit          pend1;
    res_t        pres1;
    logic [31:0] xq1, xr1;
    bit          xe1, xrdy1, xbz1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc1 <= 0; pend1 <= 0; xq1 <= '0; xr1 <= '0;
            xe1 <= 0; xrdy1 <= 0; xbz1 <= 0;
        end else begin
            cyc1  <= cyc1 + 1;
            xrdy1 <= 0;
            xe1   <= 0;
            if (st1) begin
                pres1 <= ref_div(64'(a1), 64'(b1), sg1, 32);
                due1  <= cyc1 + ((b1 == 32'd0) ? 1 : 33);
                pend1 <= 1;
                xbz1  <= 1;
            end else if (pend1 && cyc1 == due1) begin
                xq1   <= pres1.q[31:0];
                xr1   <= pres1.r[31:0];
                xe1   <= pres1.e;
                xrdy1 <= 1;
                xbz1  <= 0;
                pend1 <= 0;
            end
        end
    end

    // Model of the 8-bit instance
    longint      cyc2, due2;
    bit          pend2;
    res_t        pres2;
    logic [7:0]  xq2, xr2;
    bit          xe2, xrdy2, xbz2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc2 <= 0; pend2 <= 0; xq2 <= '0; xr2 <= '0;
            xe2 <= 0; xrdy2 <= 0; xbz2 <= 0;
        end else begin
            cyc2  <= cyc2 + 1;
            xrdy2 <= 0;
            xe2   <= 0;
            if (st2) begin
                pres2 <= ref_div(64'(a2), 64'(b2), sg2, 8);
                due2  <= cyc2 + ((b2 == 8'd0) ? 1 : 9);
                pend2 <= 1;
                xbz2  <= 1;
            end else if (pend2 && cyc2 == due2) begin
                xq2   <= pres2.q[7:0];
                xr2   <= pres2.r[7:0];
                xe2   <= pres2.e;
                xrdy2 <= 1;
                xbz2  <= 0;
                pend2 <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_q32",    64'(q1),   64'(xq1));
            chk("cyc_r32",    64'(r1),   64'(xr1));
            chk("cyc_exc32",  64'(e1),   64'(xe1));
            chk("cyc_rdy32",  64'(rdy1), 64'(xrdy1));
            chk("cyc_busy32", 64'(bz1),  64'(xbz1));
            chk("cyc_q8",     64'(q2),   64'(xq2));
            chk("cyc_r8",     64'(r2),   64'(xr2));
            chk("cyc_exc8",   64'(e2),   64'(xe2));
            chk("cyc_rdy8",   64'(rdy2), 64'(xrdy2));
            chk("cyc_busy8",  64'(bz2),  64'(xbz2));
            if (rdy1 === 1'b1) nrdy1++;
            if (rdy2 === 1'b1) nrdy2++;
        end
    end

    // One operation with ctrl_DIV held for 'hold' samples; latency counted from the last one
    task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          input bit s, input int hold, input int lat,
                          input logic [31:0] eq, input logic [31:0] er, input bit ee,
                          input string nm);
        int n;
        @(negedge clk);
        if (wide) begin a1 = a; b1 = b; sg1 = s; st1 = 1'b1; end
        else begin a2 = a[7:0]; b2 = b[7:0]; sg2 = s; st2 = 1'b1; end
        repeat (hold) @(negedge clk);
        if (wide) begin st1 = 1'b0; a1 = $urandom; b1 = $urandom; end
        else begin st2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom); end
        n = 0;
        while (((wide ? rdy1 : rdy2) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        if (wide) begin
            chk({nm, "_q"}, 64'(q1), 64'(eq));
            chk({nm, "_r"}, 64'(r1), 64'(er));
            chk({nm, "_exc"}, 64'(e1), 64'(ee));
            chk({nm, "_busy"}, 64'(bz1), 64'd0);
        end else begin
            chk({nm, "_q"}, 64'(q2), 64'(eq[7:0]));
            chk({nm, "_r"}, 64'(r2), 64'(er[7:0]));
            chk({nm, "_exc"}, 64'(e2), 64'(ee));
            chk({nm, "_busy"}, 64'(bz2), 64'd0);
        end
        @(negedge clk);
    endtask

    // First operation starts at edge 0; a second start is sampled at edge 'gap'
    task automatic restart(input int gap, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input string nm);
        int n;
        int base;
        @(negedge clk);
        a1 = a0; b1 = b0; sg1 = 1'b0; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (gap - 1) @(negedge clk);
        base = nrdy1;
        a1 = a; b1 = b; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        n = 0;
        while (rdy1 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd33);
        chk({nm, "_q"}, 64'(q1), 64'(eq));
        chk({nm, "_r"}, 64'(r1), 64'(er));
        repeat (3) @(negedge clk);
        chk({nm, "_rdy_count"}, 64'(nrdy1 - base), 64'd1);
    endtask

    initial begin
        int base;
        st1 = 0; sg1 = 0; a1 = '0; b1 = '0;
        st2 = 0; sg2 = 0; a2 = '0; b2 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_q32",    64'(q1),   64'd0);
        chk("reset_r32",    64'(r1),   64'd0);
        chk("reset_exc32",  64'(e1),   64'd0);
        chk("reset_rdy32",  64'(rdy1), 64'd0);
        chk("reset_busy32", 64'(bz1),  64'd0);
        chk("reset_busy8",  64'(bz2),  64'd0);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 32'd100,        32'd7,        0, 1, 33, 32'd14,       32'd2,        0, "u100_7");
        run_op(1, 32'hFFFFFF9C,   32'd7,        1, 1, 33, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, "s_m100_7");
        run_op(1, 32'd100,        32'hFFFFFFF9, 1, 1, 33, 32'hFFFFFFF2, 32'd2,        0, "s_100_m7");
        run_op(1, 32'hFFFFFF9C,   32'hFFFFFFF9, 1, 1, 33, 32'd14,       32'hFFFFFFFE, 0, "s_m100_m7");
        run_op(1, 32'h1234,       32'd0,        0, 1, 1,  32'hFFFFFFFF, 32'h1234,     1, "div0");
        run_op(1, 32'd9,          32'd3,        0, 1, 33, 32'd3,        32'd0,        0, "after_div0");
        run_op(1, 32'h80000000,   32'hFFFFFFFF, 1, 1, 33, 32'h80000000, 32'd0,        0, "s_overflow");
        run_op(1, 32'd1000,       32'd7,        0, 3, 33, 32'd142,      32'd6,        0, "held_start");
        run_op(0, 32'd255,        32'd16,       0, 1, 9,  32'd15,       32'd15,       0, "w8_255_16");
        run_op(0, 32'h80,         32'hFF,       1, 1, 9,  32'h80,       32'd0,        0, "w8_overflow");
        run_op(0, 32'h85,         32'd0,        1, 1, 1,  32'hFF,       32'h85,       1, "w8_div0");

        restart(10, 32'd50,  32'd5, 32'd81,   32'd9,  32'd9,   32'd0, "restart_run");
        restart(33, 32'd100, 32'd7, 32'd1000, 32'd10, 32'd100, 32'd0, "restart_fix");

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a1 = 32'd1000; b1 = 32'd3; sg1 = 1'b0; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (14) @(negedge clk);
        chk("midop_busy", 64'(bz1), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q",    64'(q1),   64'd0);
        chk("async_rst_r",    64'(r1),   64'd0);
        chk("async_rst_exc",  64'(e1),   64'd0);
        chk("async_rst_rdy",  64'(rdy1), 64'd0);
        chk("async_rst_busy", 64'(bz1),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        base = nrdy1;
        repeat (40) @(negedge clk);
        chk("no_rdy_after_rst", 64'(nrdy1 - base), 64'd0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
